vc_queue_pf: RTL and testbench

Parameterized synchronous FIFO queue with valid/ready handshakes on both ends. The producer writes through an enqueue port and the consumer reads through a dequeue port. It is the standard decoupling buffer between pipeline stages built from flip-flop state elements. Storage is a register array, with head/tail pointers and an occupancy count. There is no combinational path from the enqueue port to the dequeue port.

---
 rtl/vc_queue_pf_pkg.sv | 9 +
 rtl/vc_queue_pf_if.sv | 14 +
 rtl/vc_queue_ctrl_pf.sv | 46 ++++
 rtl/vc_queue_pf.sv | 30 +++
 tb/tb_vc_queue_pf.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/vc_queue_pf_pkg.sv
// vc_queue_pf_pkg: shared helpers and handshake encodings for the queue family
package vc_queue_pf_pkg;
  typedef enum logic [1:0] {Q_IDLE = 2'b00, Q_DEQ = 2'b01, Q_ENQ = 2'b10, Q_BOTH = 2'b11} q_op_e;
  function automatic int clog2(input int n);
    int r;
    for (r = 0; (1 << r) < n; r++) begin end
    return r;
  endfunction
endpackage

// File: rtl/vc_queue_pf_if.sv
// vc_queue_pf_if: enqueue/dequeue valid-ready bundle with occupancy
interface vc_queue_pf_if #(parameter int W = 32, parameter int ENTRIES = 4);
  import vc_queue_pf_pkg::*;
  localparam int ADDR_W = clog2(ENTRIES);
  logic [W-1:0] enq_bits_p;
  logic enq_val_p;
  logic enq_rdy_p;
  logic [W-1:0] deq_bits_p;
  logic deq_val_p;
  logic deq_rdy_p;
  logic [ADDR_W:0] count_p;
  modport master(output enq_bits_p, enq_val_p, deq_rdy_p, input enq_rdy_p, deq_bits_p, deq_val_p, count_p);
  modport slave(input enq_bits_p, enq_val_p, deq_rdy_p, output enq_rdy_p, deq_bits_p, deq_val_p, count_p);
endinterface

// File: rtl/vc_queue_ctrl_pf.sv
// vc_queue_ctrl_pf: head/tail/count bookkeeping shared by the queue variants
module vc_queue_ctrl_pf
  import vc_queue_pf_pkg::*;
#(
  parameter int ENTRIES = 4,
  localparam int AW = clog2(ENTRIES)
) (
  input  logic          clk,
  input  logic          reset_p,
  input  logic          enq_val_i,
  input  logic          deq_rdy_i,
  output logic          enq_rdy_o,
  output logic          deq_val_o,
  output logic [AW:0]   count_o,
  output logic          wen_o,
  output logic [AW-1:0] waddr_o,
  output logic [AW-1:0] raddr_o
);
  localparam logic [AW:0] FULL_CNT = ENTRIES[AW:0];
  logic [AW-1:0] head_q, tail_q;
  logic [AW:0] count_q;
  logic full, empty, enq_fire, deq_fire;
  q_op_e op;
  assign full = count_q == FULL_CNT;
  assign empty = count_q == '0;
  assign enq_rdy_o = !full && !reset_p;
  assign deq_val_o = !empty;
  assign enq_fire = enq_val_i && enq_rdy_o;
  assign deq_fire = deq_val_o && deq_rdy_i;
  assign op = q_op_e'({enq_fire, deq_fire});
  assign count_o = count_q;
  assign wen_o = enq_fire;
  assign waddr_o = tail_q;
  assign raddr_o = head_q;
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else begin
      if (enq_fire) tail_q <= tail_q + 1'b1;
      if (deq_fire) head_q <= head_q + 1'b1;
      count_q <= op == Q_ENQ ? count_q + 1'b1 : op == Q_DEQ ? count_q - 1'b1 : count_q;
    end
  end
endmodule

// File: rtl/vc_queue_pf.sv
// vc_queue_pf: flip-flop FIFO with registered status and no enq-to-deq path
module vc_queue_pf
  import vc_queue_pf_pkg::*;
#(
  parameter int W = 32,
  parameter int ENTRIES = 4,
  localparam int AW = clog2(ENTRIES)
) (
  input logic clk,
  input logic reset_p,
  vc_queue_pf_if.slave q
);
  logic [W-1:0] mem_q [ENTRIES];
  logic wen;
  logic [AW-1:0] waddr, raddr;
  vc_queue_ctrl_pf #(.ENTRIES(ENTRIES)) u_ctrl (
    .clk(clk),
    .reset_p(reset_p),
    .enq_val_i(q.enq_val_p),
    .deq_rdy_i(q.deq_rdy_p),
    .enq_rdy_o(q.enq_rdy_p),
    .deq_val_o(q.deq_val_p),
    .count_o(q.count_p),
    .wen_o(wen),
    .waddr_o(waddr),
    .raddr_o(raddr)
  );
  always_ff @(posedge clk) if (wen) mem_q[waddr] <= q.enq_bits_p;
  assign q.deq_bits_p = mem_q[raddr];
endmodule

// File: tb/tb_vc_queue_pf.sv
// tb_vc_queue_pf: queue-model scoreboard plus directed FIFO scenarios
module tb_vc_queue_pf;
  localparam int N = 4;
  logic clk = 0;
  logic reset_p = 1;
  int checks = 0;
  int errors = 0;
  logic [31:0] mdl[$];
  logic [31:0] got[$];
  bit hold_v = 0;
  logic [31:0] hold_d;
  vc_queue_pf_if #(.W(32), .ENTRIES(N)) q ();
  vc_queue_pf #(.W(32), .ENTRIES(N)) dut (.clk(clk), .reset_p(reset_p), .q(q.slave));
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state advances on the same edges as the DUT but from queue semantics only.
  always @(posedge clk or posedge reset_p) begin
    bit ef, df;
    if (reset_p) begin
      mdl.delete();
      hold_v = 0;
    end else begin
      ef = q.enq_val_p && mdl.size() < N;
      df = q.deq_rdy_p && mdl.size() > 0;
      hold_v = q.deq_val_p && !q.deq_rdy_p;
      hold_d = q.deq_bits_p;
      if (q.deq_val_p && q.deq_rdy_p) got.push_back(q.deq_bits_p);
      if (df) void'(mdl.pop_front());
      if (ef) mdl.push_back(q.enq_bits_p);
    end
  end

  always @(negedge clk) begin
    if (reset_p) begin
      chk("rst_count", 32'(q.count_p), 0);
      chk("rst_deq_val", 32'(q.deq_val_p), 0);
      chk("rst_enq_rdy", 32'(q.enq_rdy_p), 0);
    end else begin
      chk("count", 32'(q.count_p), 32'(mdl.size()));
      chk("deq_val", 32'(q.deq_val_p), 32'(mdl.size() > 0));
      chk("enq_rdy", 32'(q.enq_rdy_p), 32'(mdl.size() < N));
      if (mdl.size() > 0) chk("deq_bits", q.deq_bits_p, mdl[0]);
      if (hold_v) chk("stall_hold", q.deq_bits_p, hold_d);
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    q.deq_rdy_p = 1;
    repeat (n) cyc();
    q.deq_rdy_p = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int i, budget;
    q.enq_val_p = 0;
    q.enq_bits_p = 0;
    q.deq_rdy_p = 0;
    repeat (2) cyc();
    chk("init_count", 32'(q.count_p), 0);
    chk("init_enq_rdy", 32'(q.enq_rdy_p), 0);
    reset_p = 0;
    cyc();
    chk("post_rst_enq_rdy", 32'(q.enq_rdy_p), 1);
    chk("post_rst_deq_val", 32'(q.deq_val_p), 0);

    q.enq_val_p = 1;
    for (int k = 0; k < 4; k++) begin
      q.enq_bits_p = 32'hA1 + 32'(k);
      cyc();
    end
    chk("fill_count", 32'(q.count_p), 4);
    chk("fill_enq_rdy", 32'(q.enq_rdy_p), 0);
    q.enq_bits_p = 32'hA5;
    repeat (2) cyc();
    chk("fifth_rejected", 32'(q.count_p), 4);
    q.enq_val_p = 0;
    got.delete();
    drain(4);
    chk("drain_n", 32'(got.size()), 4);
    for (int k = 0; k < 4 && k < got.size(); k++) chk("drain_seq", got[k], 32'hA1 + 32'(k));

    q.enq_val_p = 1;
    for (int k = 1; k <= 4; k++) begin
      q.enq_bits_p = 32'(k);
      cyc();
    end
    q.enq_bits_p = 32'hB0;
    q.deq_rdy_p = 1;
    cyc();
    chk("full_both_count", 32'(q.count_p), 3);
    q.deq_rdy_p = 0;
    cyc();
    chk("b0_accept_count", 32'(q.count_p), 4);
    q.enq_val_p = 0;
    got.delete();
    drain(4);
    chk("full_both_n", 32'(got.size()), 4);
    if (got.size() == 4) begin
      chk("full_both_0", got[0], 32'h2);
      chk("full_both_3", got[3], 32'hB0);
    end

    q.enq_val_p = 1;
    q.enq_bits_p = 32'h11;
    cyc();
    q.enq_bits_p = 32'h22;
    cyc();
    got.delete();
    q.deq_rdy_p = 1;
    for (int k = 0; k < 10; k++) begin
      q.enq_bits_p = 32'(k);
      cyc();
      chk("mid_count", 32'(q.count_p), 2);
    end
    q.enq_val_p = 0;
    drain(2);
    chk("mid_n", 32'(got.size()), 12);
    if (got.size() >= 10) begin
      chk("mid_0", got[0], 32'h11);
      chk("mid_1", got[1], 32'h22);
      for (int k = 2; k < 10; k++) chk("mid_seq", got[k], 32'(k - 2));
    end

    got.delete();
    i = 0;
    budget = 0;
    while (got.size() < 16 && budget < 400) begin
      q.enq_val_p = i < 16;
      q.enq_bits_p = 32'(i);
      q.deq_rdy_p = $urandom_range(0, 9) >= 4;
      if (q.enq_val_p && q.enq_rdy_p) i++;
      cyc();
      budget++;
    end
    q.enq_val_p = 0;
    q.deq_rdy_p = 0;
    chk("wrap_n", 32'(got.size()), 16);
    for (int k = 0; k < 16 && k < got.size(); k++) chk("wrap_seq", got[k], 32'(k));

    q.enq_val_p = 1;
    q.enq_bits_p = 32'hC3;
    #1;
    chk("empty_no_bypass", 32'(q.deq_val_p), 0);
    cyc();
    q.enq_val_p = 0;
    chk("empty_after_val", 32'(q.deq_val_p), 1);
    chk("empty_after_bits", q.deq_bits_p, 32'hC3);
    drain(1);

    q.enq_val_p = 1;
    q.enq_bits_p = 32'hD1;
    cyc();
    q.enq_bits_p = 32'hD2;
    cyc();
    q.enq_val_p = 0;
    chk("pre_rst_count", 32'(q.count_p), 2);
    #2 reset_p = 1;
    #1;
    chk("async_count", 32'(q.count_p), 0);
    chk("async_deq_val", 32'(q.deq_val_p), 0);
    chk("async_enq_rdy", 32'(q.enq_rdy_p), 0);
    cyc();
    reset_p = 0;
    cyc();
    chk("rerun_enq_rdy", 32'(q.enq_rdy_p), 1);
    got.delete();
    drain(3);
    chk("no_stale_deq", 32'(got.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
